// File: rtl/wb_burst_ram_slave.sv
// rtl/wb_burst_ram_slave.sv - Wishbone slave RAM with classic and incrementing-burst support
//
// Purpose: single-port synchronous-read RAM behind a Wishbone slave port.
//   Classic cycles are acked one cycle after the request. Incrementing
//   bursts (cti 010) are acked every cycle that strobe is high, with linear
//   or wrap-4/8/16 address sequencing. Out-of-range words end with err.
//
// Ports:
//   wb_clk_i   clock, all state changes on its rising edge
//   wb_rst_ni  asynchronous active-low reset (memory contents are kept)
//   wb_adr_i   byte address, word index is wb_adr_i[aw-1:2]
//   wb_dat_i   write data          wb_sel_i  byte lane enables
//   wb_we_i    write enable        wb_cyc_i  cycle valid
//   wb_stb_i   strobe              wb_cti_i  cycle type (010 burst, 111 end)
//   wb_bte_i   burst type (00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16)
//   wb_dat_o   read data           wb_ack_o  normal termination
//   wb_err_o   error termination   wb_rty_o  retry, always 0

module wb_burst_ram_slave #(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int DEPTH = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int iw = aw - 2;
  localparam int mw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int nb = dw / 8;
  localparam logic [iw-1:0] depth_w = iw'(DEPTH);

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [iw-1:0] burst_adr, adr_nxt, adr_inc, wrap_mask, req_idx;
  logic          req, in_range, ack, err, wr_en;
  logic          unused_adr_lsbs;
  logic [dw-1:0] mem [DEPTH];

  assign req             = wb_cyc_i & wb_stb_i;
  assign req_idx         = wb_adr_i[aw-1:2];
  assign in_range        = burst_adr < depth_w;
  assign unused_adr_lsbs = ^wb_adr_i[1:0];

  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask = iw'(3);
      2'b10:   wrap_mask = iw'(7);
      2'b11:   wrap_mask = iw'(15);
      default: wrap_mask = '0;
    endcase
  end

  // Wrap bursts only carry into the low bits selected by the mask; the
  // upper bits stay fixed so the burst circles within its aligned block.
  assign adr_inc = (wb_bte_i == 2'b00) ? burst_adr + iw'(1)
                 : (burst_adr & ~wrap_mask) | ((burst_adr + iw'(1)) & wrap_mask);

  always_comb begin
    state_nxt = state;
    adr_nxt   = burst_adr;
    ack       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          adr_nxt   = req_idx;
          state_nxt = (wb_cti_i == 3'b010 && req_idx < depth_w) ? BURST : SINGLE;
        end
      end
      SINGLE: begin
        ack       = wb_cyc_i & in_range;
        err       = wb_cyc_i & ~in_range;
        state_nxt = IDLE;
      end
      BURST: begin
        if (!wb_cyc_i) begin
          state_nxt = IDLE;
        end else if (wb_stb_i) begin
          if (in_range) begin
            ack     = 1'b1;
            adr_nxt = adr_inc;
            if (wb_cti_i == 3'b111) state_nxt = IDLE;
          end else begin
            // linear burst ran off the end of the array
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The read register is loaded from the address the next cycle will use,
  // so back-to-back burst beats see their data without a wait state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      burst_adr <= '0;
      wb_dat_o  <= '0;
    end else begin
      state     <= state_nxt;
      burst_adr <= adr_nxt;
      wb_dat_o  <= mem[adr_nxt[mw-1:0]];
    end
  end

  // ack is only raised for in-range words, and is forced low by reset
  // through the state register, so no write escapes during reset.
  assign wr_en = ack & wb_we_i;

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < nb; i++) begin
        if (wb_sel_i[i]) mem[burst_adr[mw-1:0]][i*8 +: 8] <= wb_dat_i[i*8 +: 8];
      end
    end
  end

  assign wb_ack_o = ack;
  assign wb_err_o = err;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// tb/tb_wb_burst_ram_slave.sv - randomized self-checking bench for wb_burst_ram_slave

module tb_wb_burst_ram_slave;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [DW-1:0] dat_r;
  logic          ack, err, rty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DEPTH];

  wb_burst_ram_slave #(.dw(DW), .aw(AW), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_w),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_r),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i]) ref_mem[idx][i*8 +: 8] = d[i*8 +: 8];
  endfunction

  // Word visited by beat k of a burst starting at word 'start'.
  function automatic int beat_addr(input int start, input logic [1:0] b, input int k);
    int n;
    if (b == 2'b00) return start + k;
    n = 2 << b;
    return start - (start % n) + ((start % n) + k) % n;
  endfunction

  // One bus cycle: drive on the falling edge, settle, then sample.
  task automatic step(input logic c, input logic s, input logic w, input int idx,
                      input logic [31:0] d, input logic [3:0] m,
                      input logic [2:0] t, input logic [1:0] b);
    @(negedge clk);
    cyc = c; stb = s; we = w; adr = AW'(idx * 4); dat_w = d; sel = m; cti = t; bte = b;
    #1;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 3'b000, 2'b00);
    check_eq("idle_ack", 32'(ack), 32'd0);
    check_eq("idle_err", 32'(err), 32'd0);
  endtask

  task automatic classic(input logic w, input int idx, input logic [31:0] d,
                         input logic [3:0] m, output logic [31:0] rd);
    logic [2:0] t;
    logic [1:0] b;
    logic       inr;
    do t = 3'($urandom_range(7)); while (t == 3'b010);
    b   = 2'($urandom_range(3));
    inr = (idx < DEPTH);
    step(1'b1, 1'b1, w, idx, d, m, t, b);
    check_eq("cl_lat_ack", 32'(ack), 32'd0);
    check_eq("cl_lat_err", 32'(err), 32'd0);
    step(1'b1, 1'b1, w, idx, d, m, t, b);
    check_eq("cl_ack", 32'(ack), 32'(inr));
    check_eq("cl_err", 32'(err), 32'(!inr));
    check_eq("cl_rty", 32'(rty), 32'd0);
    rd = dat_r;
    if (inr && !w) check_eq("cl_rdata", dat_r, ref_mem[idx]);
    if (inr && w) model_write(idx, d, m);
  endtask

  // wait_at: beat index preceded by one forced wait state (-1 none).
  // abort_at: beat index at which cyc is dropped instead (-1 none).
  task automatic burst(input logic w, input int start, input logic [1:0] b, input int nbeats,
                       input int wait_pct, input int wait_at, input int abort_at);
    int          k, a, guard;
    logic        waited, done;
    logic [31:0] d;
    logic [3:0]  m;
    k = 0; guard = 0; waited = 1'b0; done = 1'b0;
    step(1'b1, 1'b1, w, start, $urandom, 4'hF, 3'b010, b);
    check_eq("bu_lat_ack", 32'(ack), 32'd0);
    check_eq("bu_lat_err", 32'(err), 32'd0);
    while (!done && k < nbeats && guard < 4 * nbeats + 8) begin
      guard++;
      if (k == abort_at) begin
        step(1'b0, 1'b0, w, 0, 32'h0, 4'h0, 3'b000, b);
        check_eq("bu_abort_ack", 32'(ack), 32'd0);
        check_eq("bu_abort_err", 32'(err), 32'd0);
        done = 1'b1;
      end else if ((k == wait_at && !waited) || int'($urandom_range(99)) < wait_pct) begin
        if (k == wait_at) waited = 1'b1;
        step(1'b1, 1'b0, w, beat_addr(start, b, k), $urandom, 4'hF, 3'b010, b);
        check_eq("bu_wait_ack", 32'(ack), 32'd0);
        check_eq("bu_wait_err", 32'(err), 32'd0);
      end else begin
        a = beat_addr(start, b, k);
        d = $urandom;
        m = 4'($urandom_range(15));
        step(1'b1, 1'b1, w, a, d, m, (k == nbeats - 1) ? 3'b111 : 3'b010, b);
        if (a < DEPTH) begin
          check_eq("bu_ack", 32'(ack), 32'd1);
          check_eq("bu_err", 32'(err), 32'd0);
          if (!w) check_eq("bu_rdata", dat_r, ref_mem[a]);
          else model_write(a, d, m);
          k++;
        end else begin
          check_eq("bu_oor_ack", 32'(ack), 32'd0);
          check_eq("bu_oor_err", 32'(err), 32'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] d;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0; cti = '0; bte = '0;
    #12;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rty", 32'(rty), 32'd0);
    check_eq("rst_dat", dat_r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fill the whole array so every later read has a known value
    for (int i = 0; i < DEPTH; i++) classic(1'b1, i, $urandom, 4'hF, rd);

    classic(1'b1, 4, 32'hDEADBEEF, 4'hF, rd);
    classic(1'b0, 4, 32'h0, 4'h0, rd);
    check_eq("dir_deadbeef", rd, 32'hDEADBEEF);

    classic(1'b1, 5, 32'h11223344, 4'hF, rd);
    classic(1'b1, 5, 32'h000000AA, 4'h1, rd);
    classic(1'b0, 5, 32'h0, 4'h0, rd);
    check_eq("dir_byte_lane", rd, 32'h112233AA);

    burst(1'b0, 6, 2'b01, 4, 0, -1, -1);
    classic(1'b0, 0, 32'h0, 4'h0, rd);

    burst(1'b1, 0, 2'b00, 8, 0, 3, -1);
    burst(1'b0, 0, 2'b00, 8, 0, -1, -1);

    burst(1'b1, DEPTH - 2, 2'b00, 3, 0, -1, -1);
    classic(1'b0, 0, 32'h0, 4'h0, rd);
    classic(1'b0, DEPTH - 2, 32'h0, 4'h0, rd);
    classic(1'b0, DEPTH - 1, 32'h0, 4'h0, rd);

    classic(1'b0, DEPTH, 32'h0, 4'h0, rd);
    classic(1'b1, DEPTH + 1, 32'hFFFFFFFF, 4'hF, rd);

    burst(1'b0, 10, 2'b00, 6, 0, -1, 2);
    classic(1'b0, 11, 32'h0, 4'h0, rd);

    // reset in the middle of a write burst: beats 20,21 land, 22 is aborted
    step(1'b1, 1'b1, 1'b1, 20, 32'h0, 4'hF, 3'b010, 2'b00);
    check_eq("mr_lat_ack", 32'(ack), 32'd0);
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      step(1'b1, 1'b1, 1'b1, 20 + k, d, 4'hF, 3'b010, 2'b00);
      check_eq("mr_beat_ack", 32'(ack), 32'd1);
      model_write(20 + k, d, 4'hF);
    end
    step(1'b1, 1'b1, 1'b1, 22, 32'hBADC0FFE, 4'hF, 3'b010, 2'b00);
    check_eq("mr_pre_rst_ack", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_rst_ack", 32'(ack), 32'd0);
    check_eq("mr_rst_err", 32'(err), 32'd0);
    check_eq("mr_rst_dat", dat_r, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    classic(1'b0, 22, 32'h0, 4'h0, rd);
    classic(1'b0, 21, 32'h0, 4'h0, rd);
    classic(1'b0, 20, 32'h0, 4'h0, rd);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1) == 0) begin
        classic(1'($urandom_range(1)), int'($urandom_range(DEPTH + 3)), $urandom,
                4'($urandom_range(15)), rd);
      end else begin
        burst(1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)), 2'($urandom_range(3)),
              int'($urandom_range(20, 1)), 25, -1, -1);
      end
      for (int g = int'($urandom_range(2)); g > 0; g--) idle_cycle();
    end

    burst(1'b0, 0, 2'b00, DEPTH, 10, -1, -1);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
